bldc_motor_emulator: RTL and testbench

Synthesizable BLDC motor plant model for hardware-in-the-loop test builds.
- Consumes the six gate-drive lines a BLDC motor driver produces.
- Models commutation torque direction, PWM duty and first-order speed response.
- Emits the hall code and quadrature encoder signals that the motor, hall-counter and encoder-counter blocks consume, closing the loop on the FPGA with no physical motor attached.

---
 rtl/bldc_motor_emulator.sv | 191 +++++++++++++++++++
 tb/tb_bldc_motor_emulator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bldc_motor_emulator.sv
// BLDC motor plant model: decodes gate drive into torque, filters speed, emits hall and quadrature.
// Latency: enc/sector 1 clk after accumulator carry; hall 1 clk after sector; fault override combinational.
// Backpressure: none; free-running plant, en=0 freezes model state (shoot_through still detected).
module bldc_motor_emulator #(
  parameter int PWM_PERIOD     = 1022,
  parameter int DUTY_WIDTH     = 10,
  parameter int ACCEL_SHIFT    = 4,
  parameter int ACC_WIDTH      = 16,
  parameter int ENC_PER_SECTOR = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [2:0]                   phaseH,
  input  logic [2:0]                   phaseL,
  input  logic [1:0]                   fault_inj,
  output logic [2:0]                   hall,
  output logic [1:0]                   enc,
  output logic [2:0]                   sector,
  output logic signed [DUTY_WIDTH+1:0] speed,
  output logic                         shoot_through
);

  localparam int SW = DUTY_WIDTH + 2;
  localparam int WW = $clog2(PWM_PERIOD);
  localparam int EW = (ENC_PER_SECTOR > 1) ? $clog2(ENC_PER_SECTOR) : 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(PWM_PERIOD - 1);
  localparam logic [EW-1:0] SUB_LAST = EW'(ENC_PER_SECTOR - 1);

  logic [WW-1:0]         win_cnt;
  logic [DUTY_WIDTH-1:0] duty_cnt;
  logic signed [SW-1:0]  target;
  logic                  upd_pend;
  logic [ACC_WIDTH-1:0]  acc;
  logic [EW-1:0]         sub_cnt;
  logic [2:0]            hall_reg;

  logic                  vec_ok;
  logic [2:0]            k;
  logic [3:0]            off_raw;
  logic [3:0]            off;
  logic                  dir_pos;
  logic                  dir_neg;
  logic                  win_wrap;
  logic [DUTY_WIDTH-1:0] duty_sum;
  logic signed [SW-1:0]  mag;
  logic signed [SW-1:0]  target_nxt;
  logic signed [SW-1:0]  diff;
  logic signed [SW-1:0]  step;
  logic signed [SW-1:0]  speed_nxt;
  logic [SW-1:0]         abs_spd;
  logic [ACC_WIDTH:0]    acc_sum;
  logic                  carry;
  logic [1:0]            enc_fwd;
  logic [1:0]            enc_rev;
  logic [2:0]            sector_fwd;
  logic [2:0]            sector_rev;

  // Decode the gate-drive vector; only the six single-high/single-low pairs give torque.
  always_comb begin
    vec_ok = 1'b1;
    k      = 3'd0;
    case ({phaseH, phaseL})
      6'b001_010: k = 3'd0;
      6'b001_100: k = 3'd1;
      6'b010_100: k = 3'd2;
      6'b010_001: k = 3'd3;
      6'b100_001: k = 3'd4;
      6'b100_010: k = 3'd5;
      default:    vec_ok = 1'b0;
    endcase
  end

  // Torque direction from the electrical offset between applied vector and rotor sector.
  always_comb begin
    off_raw = {1'b0, k} + 4'd6 - {1'b0, sector};
    off     = (off_raw >= 4'd6) ? off_raw - 4'd6 : off_raw;
    dir_pos = vec_ok && (off == 4'd1 || off == 4'd2);
    dir_neg = vec_ok && (off == 4'd4 || off == 4'd5);
  end

  // Window arithmetic, first-order speed filter and position accumulator.
  always_comb begin
    win_wrap   = (win_cnt == WIN_LAST);
    duty_sum   = duty_cnt + {{(DUTY_WIDTH-1){1'b0}}, (dir_pos | dir_neg)};
    mag        = $signed({2'b00, duty_sum});
    target_nxt = dir_neg ? -mag : (dir_pos ? mag : '0);
    // |target| and |speed| stay within PWM_PERIOD, so the difference fits in SW bits.
    diff       = target - speed;
    step       = diff >>> ACCEL_SHIFT;
    speed_nxt  = speed + step;
    abs_spd    = speed[SW-1] ? -speed : speed;
    acc_sum    = {1'b0, acc} + {{(ACC_WIDTH+1-SW){1'b0}}, abs_spd};
    carry      = acc_sum[ACC_WIDTH];
  end

  // Next quadrature code and sector for a step in either direction.
  always_comb begin
    case (enc)
      2'b00:   begin enc_fwd = 2'b01; enc_rev = 2'b10; end
      2'b01:   begin enc_fwd = 2'b11; enc_rev = 2'b00; end
      2'b11:   begin enc_fwd = 2'b10; enc_rev = 2'b01; end
      default: begin enc_fwd = 2'b00; enc_rev = 2'b11; end
    endcase
    sector_fwd = (sector == 3'd5) ? 3'd0 : sector + 3'd1;
    sector_rev = (sector == 3'd0) ? 3'd5 : sector - 3'd1;
  end

  // Duty measurement window; target latched on wrap, speed filtered one clock later.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt  <= '0;
      duty_cnt <= '0;
      target   <= '0;
      upd_pend <= 1'b0;
      speed    <= '0;
    end else if (en) begin
      upd_pend <= win_wrap;
      if (upd_pend) speed <= speed_nxt;
      if (win_wrap) begin
        win_cnt  <= '0;
        duty_cnt <= '0;
        target   <= target_nxt;
      end else begin
        win_cnt  <= win_cnt + WW'(1);
        duty_cnt <= duty_sum;
      end
    end
  end

  // Integrate |speed|; each accumulator carry is one quadrature step in the sign of speed.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      enc     <= 2'b00;
      sub_cnt <= '0;
      sector  <= 3'd0;
    end else if (en) begin
      acc <= acc_sum[ACC_WIDTH-1:0];
      if (carry && !speed[SW-1]) begin
        enc <= enc_fwd;
        if (sub_cnt == SUB_LAST) begin
          sub_cnt <= '0;
          sector  <= sector_fwd;
        end else begin
          sub_cnt <= sub_cnt + EW'(1);
        end
      end else if (carry && speed[SW-1]) begin
        enc <= enc_rev;
        if (sub_cnt == '0) begin
          sub_cnt <= SUB_LAST;
          sector  <= sector_rev;
        end else begin
          sub_cnt <= sub_cnt - EW'(1);
        end
      end
    end
  end

  // Hall code registered from the sector.
  always_ff @(posedge clk) begin
    if (reset) begin
      hall_reg <= 3'b001;
    end else begin
      case (sector)
        3'd0:    hall_reg <= 3'b001;
        3'd1:    hall_reg <= 3'b011;
        3'd2:    hall_reg <= 3'b010;
        3'd3:    hall_reg <= 3'b110;
        3'd4:    hall_reg <= 3'b100;
        default: hall_reg <= 3'b101;
      endcase
    end
  end

  // Sticky shoot-through detector, live even while the model is frozen.
  always_ff @(posedge clk) begin
    if (reset) shoot_through <= 1'b0;
    else if ((phaseH & phaseL) != 3'b000) shoot_through <= 1'b1;
  end

  // Fault injection overrides only the visible hall code.
  always_comb begin
    case (fault_inj)
      2'b01:   hall = 3'b000;
      2'b10:   hall = 3'b111;
      default: hall = hall_reg;
    endcase
  end

endmodule

// File: tb/tb_bldc_motor_emulator.sv
// Directed bench for bldc_motor_emulator: reset, forward/reverse drive, freeze, faults, shoot-through.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Summary line reports total comparisons and failures.
module tb_bldc_motor_emulator;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic [2:0]        phaseH;
  logic [2:0]        phaseL;
  logic [1:0]        fault_inj;
  logic [2:0]        hall;
  logic [1:0]        enc;
  logic [2:0]        sector;
  logic signed [11:0] speed;
  logic              shoot_through;

  int checks = 0;
  int errors = 0;

  bldc_motor_emulator #(
    .PWM_PERIOD(1022), .DUTY_WIDTH(10), .ACCEL_SHIFT(4), .ACC_WIDTH(16), .ENC_PER_SECTOR(8)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .phaseH(phaseH), .phaseL(phaseL),
    .fault_inj(fault_inj), .hall(hall), .enc(enc), .sector(sector),
    .speed(speed), .shoot_through(shoot_through)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  function automatic logic [1:0] fwd_next(input logic [1:0] e);
    case (e)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_next(input logic [1:0] e);
    case (e)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  initial begin
    logic [1:0] prev;
    int steps;
    int bad;

    reset = 1'b1; en = 1'b1; phaseH = 3'b000; phaseL = 3'b000; fault_inj = 2'b00;

    // Reset state and static outputs with no drive
    do_reset();
    check("rst_hall", hall, 3'b001);
    check("rst_enc", enc, 0);
    check("rst_sector", sector, 0);
    check("rst_speed", speed, 0);
    check("rst_shoot", shoot_through, 0);
    bad = 0;
    for (int i = 0; i < 3 * 1022; i++) begin
      tick(1);
      if (hall !== 3'b001 || enc !== 2'b00 || sector !== 3'd0 || speed !== 12'sd0 || shoot_through !== 1'b0)
        bad++;
    end
    check("idle_static_bad_clocks", bad, 0);

    // Forward drive k=1 at sector 0: filter response across window boundaries
    phaseH = 3'b001; phaseL = 3'b100;
    do_reset();
    tick(1022);
    check("fwd_speed_before_upd1", speed, 0);
    tick(1);
    check("fwd_speed_upd1", speed, 63);
    tick(1021);
    check("fwd_speed_before_upd2", speed, 63);
    tick(1);
    check("fwd_speed_upd2", speed, 122);
    check("fwd_enc_pre", enc, 0);

    // Freeze: everything holds, then resumes where it stopped
    en = 1'b0;
    tick(300);
    check("frz_speed", speed, 122);
    check("frz_enc", enc, 0);
    check("frz_sector", sector, 0);
    en = 1'b1;

    // Forward stepping until one full sector (8 steps)
    prev = 2'b00;
    steps = 0;
    for (int i = 1; i <= 20000 && steps < 8; i++) begin
      tick(1);
      if (i == 1021) check("fwd_speed_before_upd3", speed, 122);
      if (i == 1022) check("fwd_speed_upd3", speed, 178);
      if (enc !== prev) begin
        check("fwd_enc_seq", enc, fwd_next(prev));
        prev = enc;
        steps++;
      end
    end
    check("fwd_steps", steps, 8);
    check("fwd_enc_after8", enc, 0);
    check("fwd_sector_after8", sector, 1);
    check("fwd_hall_lag", hall, 3'b001);
    tick(1);
    check("fwd_hall_sector1", hall, 3'b011);

    // Fault injection overrides hall while the sector keeps moving
    fault_inj = 2'b01;
    #1;
    check("fault01_hall", hall, 3'b000);
    fault_inj = 2'b10;
    #1;
    check("fault10_hall", hall, 3'b111);
    for (int i = 0; i < 30000 && sector != 3'd2; i++) tick(1);
    check("fault_sector_advanced", sector, 2);
    check("fault10_hall_hold", hall, 3'b111);
    tick(1);
    fault_inj = 2'b00;
    #1;
    check("fault_clear_hall", hall, 3'b010);

    // Reverse drive k=4 at sector 0; reset asserted mid-operation
    phaseH = 3'b100; phaseL = 3'b001;
    do_reset();
    check("midrst_hall", hall, 3'b001);
    check("midrst_enc", enc, 0);
    check("midrst_sector", sector, 0);
    check("midrst_speed", speed, 0);
    tick(1023);
    check("rev_speed_upd1", speed, -64);
    prev = 2'b00;
    steps = 0;
    for (int i = 0; i < 5000 && enc == 2'b00; i++) tick(1);
    check("rev_enc_step1", enc, 2'b10);
    check("rev_sector_step1", sector, 5);
    tick(1);
    check("rev_hall_sector5", hall, 3'b101);
    prev = enc;
    for (int i = 0; i < 10000 && steps < 3; i++) begin
      tick(1);
      if (enc !== prev) begin
        check("rev_enc_seq", enc, rev_next(prev));
        prev = enc;
        steps++;
      end
    end
    check("rev_steps", steps, 3);
    check("rev_enc_final", enc, 0);
    check("rev_speed_negative", speed < 0, 1);

    // Shoot-through: set while frozen, sticky through valid vectors, cleared by reset
    check("shoot_clear_pre", shoot_through, 0);
    en = 1'b0;
    phaseH = 3'b001; phaseL = 3'b001;
    tick(1);
    check("shoot_set", shoot_through, 1);
    phaseH = 3'b100; phaseL = 3'b001; en = 1'b1;
    tick(50);
    check("shoot_sticky", shoot_through, 1);
    do_reset();
    check("shoot_reset", shoot_through, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
